// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter for the ALU shift path.
//
// It supports sll, srl, sra and rol by a variable amount from 0 to WIDTH-1.
// The shift is split into SHAMT_W binary levels, where level i shifts by 2**i.
// The levels run in ascending order. They are spread over PIPE_STAGES
// register stages, and the leading stages take the extra level when the
// split is uneven. The latency is PIPE_STAGES cycles, and the unit can
// produce one result per cycle.
//
// Optional feature: define SHIFT_PIPE_ROTATE_EN to build rotate-left for
// op 11. Without it, op 11 behaves exactly like sll.
//
// Parameters:
//   WIDTH        data width, a power of two from 8 to 64
//   SHAMT_W      shift-amount width, derived as $clog2(WIDTH)
//   PIPE_STAGES  number of register stages (1..SHAMT_W), which is also the latency
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; drops every in-flight operand
//   in_valid   operand valid
//   in_ready   unit accepts an operand this cycle (global advance)
//   in_data    operand
//   in_shamt   shift amount, unsigned
//   in_op      00 sll, 01 srl, 10 sra, 11 rol
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   shifted result
//   out_zero   out_data == 0, decoded from the final stage register
`timescale 1ns/1ps

module shift_pipe #(
  parameter int unsigned  WIDTH       = 32,
  localparam int unsigned SHAMT_W     = $clog2(WIDTH),
  parameter int unsigned  PIPE_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // Number of shift levels handled by stage s. The first
  // (SHAMT_W % PIPE_STAGES) stages take one extra level.
  function automatic int unsigned stage_cnt(input int unsigned s);
    return (SHAMT_W / PIPE_STAGES) + ((s < (SHAMT_W % PIPE_STAGES)) ? 32'd1 : 32'd0);
  endfunction

  // Index of the first level handled by stage s.
  function automatic int unsigned stage_lo(input int unsigned s);
    return s * (SHAMT_W / PIPE_STAGES) +
           ((s < (SHAMT_W % PIPE_STAGES)) ? s : (SHAMT_W % PIPE_STAGES));
  endfunction

  // Shift by one fixed level amount k. For sra, fill carries the sign bit
  // captured at the input, so the result does not depend on the current MSB.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input int unsigned      k,
    input op_e              op,
    input logic             fill
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_SRL:  r = d >> k;
      OP_SRA:  r = (d >> k) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> k));
`ifdef SHIFT_PIPE_ROTATE_EN
      OP_ROL:  r = (d << k) | (d >> (WIDTH - k));
`endif
      default: r = d << k;
    endcase
    return r;
  endfunction

  logic advance;

  // A single global advance: stages never collapse bubbles, so the whole
  // pipe moves together or holds together.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int unsigned LO      = stage_lo(s);
    localparam int unsigned CNT     = stage_cnt(s);
    localparam int unsigned SH_IN_W = SHAMT_W - LO;

    logic               v_in;
    logic [WIDTH-1:0]   d_in;
    logic [SH_IN_W-1:0] sh_in;
    op_e                op_in;
    logic               fill_in;
    logic [WIDTH-1:0]   lvl [CNT+1];
    logic               v_q;
    logic [WIDTH-1:0]   d_q;

    if (s == 0) begin : g_src
      assign v_in    = in_valid;
      assign d_in    = in_data;
      assign sh_in   = in_shamt;
      assign op_in   = op_e'(in_op);
      assign fill_in = in_data[WIDTH-1];
    end else begin : g_src
      assign v_in    = g_stage[s-1].v_q;
      assign d_in    = g_stage[s-1].d_q;
      assign sh_in   = g_stage[s-1].g_fwd.rem_q;
      assign op_in   = g_stage[s-1].g_fwd.op_q;
      assign fill_in = g_stage[s-1].g_fwd.fill_q;
    end

    // sh_in[0] is the shift-amount bit for level LO.
    assign lvl[0] = d_in;
    for (genvar l = 0; l < CNT; l++) begin : g_lvl
      assign lvl[l+1] = sh_in[l]
                      ? shift_level(lvl[l], 32'd1 << (LO + l), op_in, fill_in)
                      : lvl[l];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        d_q <= lvl[CNT];
      end
    end

    // Every stage except the last also carries the unused shift-amount bits,
    // the op and the sign fill forward to the next stage.
    if (s < PIPE_STAGES - 1) begin : g_fwd
      localparam int unsigned REM_W = SH_IN_W - CNT;

      logic [REM_W-1:0] rem_q;
      op_e              op_q;
      logic             fill_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          rem_q  <= '0;
          op_q   <= OP_SLL;
          fill_q <= 1'b0;
        end else if (advance) begin
          rem_q  <= sh_in[SH_IN_W-1:CNT];
          op_q   <= op_in;
          fill_q <= fill_in;
        end
      end
    end
  end

  assign out_valid = g_stage[PIPE_STAGES-1].v_q;
  assign out_data  = g_stage[PIPE_STAGES-1].d_q;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe. It uses three instances:
//   u_p2 (PIPE_STAGES=2) for directed cases, the stall stream and the reset case.
//   u_p1 (PIPE_STAGES=1) and u_p5 (PIPE_STAGES=5) for a random sweep against an
//   arithmetic reference model.
// Inputs are driven and outputs are sampled 1ns after the rising edge.
`timescale 1ns/1ps

module tb_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_iv, a_ir, a_ov, a_or, a_oz;
  logic [31:0] a_id, a_od;
  logic [4:0]  a_sh;
  logic [1:0]  a_op;

  logic        s_iv, s_or;
  logic [31:0] s_id;
  logic [4:0]  s_sh;
  logic [1:0]  s_op;
  logic        b_ir, b_ov, b_oz;
  logic [31:0] b_od;
  logic        c_ir, c_ov, c_oz;
  logic [31:0] c_od;

  shift_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u_p2 (
    .clock(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_shamt(a_sh), .in_op(a_op), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .out_zero(a_oz));

  shift_pipe #(.WIDTH(32), .PIPE_STAGES(1)) u_p1 (
    .clock(clk), .reset(reset), .in_valid(s_iv), .in_ready(b_ir), .in_data(s_id),
    .in_shamt(s_sh), .in_op(s_op), .out_valid(b_ov), .out_ready(s_or),
    .out_data(b_od), .out_zero(b_oz));

  shift_pipe #(.WIDTH(32), .PIPE_STAGES(5)) u_p5 (
    .clock(clk), .reset(reset), .in_valid(s_iv), .in_ready(c_ir), .in_data(s_id),
    .in_shamt(s_sh), .in_op(s_op), .out_valid(c_ov), .out_ready(s_or),
    .out_data(c_od), .out_zero(c_oz));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model written directly from the shift definitions.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return sd >>> s;
`ifdef SHIFT_PIPE_ROTATE_EN
      default: return (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - s)));
`else
      default: return d << s;
`endif
    endcase
  endfunction

  // One isolated operation on u_p2 with out_ready=1. The result must appear
  // exactly two cycles after the operand is presented.
  task automatic single_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                           input logic [1:0] op, input logic [31:0] exp);
    a_iv = 1'b1; a_id = d; a_sh = sh; a_op = op;
    #1;
    check({tag, "_in_ready"}, a_ir, 1);
    @(posedge clk); #1;
    a_iv = 1'b0; a_id = 'x; a_sh = 'x; a_op = 'x;
    check({tag, "_valid_early"}, a_ov, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, a_ov, 1);
    check({tag, "_data"},  a_od, exp);
    check({tag, "_zero"},  a_oz, (exp == 32'd0) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] sd_tab [6];
  logic [4:0]  ss_tab [6];
  logic [1:0]  so_tab [6];
  logic [31:0] q [$];
  int          sent, got;
  localparam int N = 200;
  logic        hv [N+6];
  logic [31:0] hd [N+6];

  initial begin
    reset = 1'b1;
    a_iv = 1'b0; a_id = '0; a_sh = '0; a_op = '0; a_or = 1'b1;
    s_iv = 1'b0; s_id = '0; s_sh = '0; s_op = '0; s_or = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_out_valid", a_ov, 0);
    check("rst_out_data",  a_od, 32'h0);
    check("rst_out_zero",  a_oz, 1);
    check("rst_in_ready",  a_ir, 1);

    // Directed cases
    single_op("sll16",    32'h0000ABCD, 5'd16, 2'b00, 32'hABCD0000);
    single_op("sll0",     32'h12345678, 5'd0,  2'b00, 32'h12345678);
    single_op("srl31",    32'h80000000, 5'd31, 2'b01, 32'h00000001);
    single_op("sra31",    32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF);
    single_op("sra30",    32'h40000000, 5'd30, 2'b10, 32'h00000001);
    single_op("sll31",    32'h00000001, 5'd31, 2'b00, 32'h80000000);
    single_op("srl1",     32'h80000000, 5'd1,  2'b01, 32'h40000000);
    single_op("srl_zero", 32'h00000001, 5'd1,  2'b01, 32'h00000000);
`ifdef SHIFT_PIPE_ROTATE_EN
    single_op("rol4",     32'h80000001, 5'd4,  2'b11, 32'h00000018);
`else
    single_op("rol4",     32'h80000001, 5'd4,  2'b11, 32'h00000010);
`endif

    // Back-to-back stream of six ops with out_ready low for cycles 3..5
    for (int i = 0; i < 6; i++) begin
      sd_tab[i] = $urandom;
      ss_tab[i] = 5'($urandom_range(0, 31));
      so_tab[i] = 2'($urandom_range(0, 3));
    end
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      a_or = !(c >= 3 && c <= 5);
      a_iv = (sent < 6);
      if (sent < 6) begin
        a_id = sd_tab[sent]; a_sh = ss_tab[sent]; a_op = so_tab[sent];
      end
      #1;
      if (c < 10) check("stream_in_ready", a_ir, (c >= 3 && c <= 5) ? 0 : 1);
      if (a_ov) begin
        if (q.size() == 0) check("stream_extra", a_ov, 0);
        else if (a_or) begin
          check("stream_data", a_od, q[0]);
          void'(q.pop_front());
          got++;
        end else check("stream_hold", a_od, q[0]);
      end
      if (a_iv && a_ir) begin
        q.push_back(model(a_id, a_sh, a_op));
        sent++;
      end
      @(posedge clk); #1;
    end
    a_iv = 1'b0; a_or = 1'b1;
    check("stream_count", got, 6);
    repeat (2) @(posedge clk);
    #1 check("stream_no_dup", a_ov, 0);

    // Reset with two ops in flight; out_ready is held low so neither is emitted
    a_or = 1'b0;
    a_iv = 1'b1; a_id = 32'h00000F00; a_sh = 5'd4; a_op = 2'b00;
    @(posedge clk); #1;
    a_id = 32'h12345678; a_sh = 5'd8; a_op = 2'b01;
    check("rstmid_accept2", a_ir, 1);
    @(posedge clk); #1;
    a_iv = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; a_or = 1'b1;
    check("rstmid_valid", a_ov, 0);
    check("rstmid_zero",  a_oz, 1);
    repeat (2) @(posedge clk);
    #1 check("rstmid_valid_late", a_ov, 0);
    single_op("rst_next", 32'hF0000000, 5'd4, 2'b01, 32'h0F000000);

    // Random sweep on PIPE_STAGES=1 and PIPE_STAGES=5 with out_ready=1
    for (int c = 0; c < N + 6; c++) begin
      if (c < N) begin
        s_iv = ($urandom_range(0, 3) != 0);
        s_id = $urandom;
        s_sh = 5'($urandom_range(0, 31));
        s_op = 2'($urandom_range(0, 3));
        hv[c] = s_iv;
        hd[c] = model(s_id, s_sh, s_op);
      end else begin
        s_iv = 1'b0;
        hv[c] = 1'b0;
        hd[c] = '0;
      end
      @(posedge clk); #1;
      check("p1_valid", b_ov, hv[c]);
      if (hv[c]) begin
        check("p1_data", b_od, hd[c]);
        check("p1_zero", b_oz, (hd[c] == 32'd0) ? 1 : 0);
      end
      if (c >= 4) begin
        check("p5_valid", c_ov, hv[c-4]);
        if (hv[c-4]) check("p5_data", c_od, hd[c-4]);
      end else check("p5_valid_fill", c_ov, 0);
      if (c == 50) begin
        check("p1_in_ready", b_ir, 1);
        check("p5_in_ready", c_ir, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
